// File: rtl/bsg_packed_cmd_executor.sv
// bsg_packed_cmd_executor
// Executes packed {write_not_read, addr[22:0], data[7:0]} commands one at a
// time against a byte-wide memory port. Reads return {24'b0, byte} on the
// response stream. A per-command timeout keeps a dead target from hanging
// the upstream master.
module bsg_packed_cmd_executor #(
  parameter int          timeout_p      = 1024,
  parameter logic [31:0] timeout_data_p = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] data_i,
  input  logic        v_i,
  output logic        ready_o,
  output logic [31:0] data_o,
  output logic        v_o,
  input  logic        ready_i,
  output logic        mem_v_o,
  output logic        mem_w_o,
  output logic [22:0] mem_addr_o,
  output logic [7:0]  mem_data_o,
  input  logic        mem_ready_i,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_v_i,
  output logic [7:0]  timeout_count_o
);

  // A zero timeout disables the counter; keep at least one bit so the
  // declaration stays legal.
  localparam int cnt_w = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;
  localparam bit timeout_en = (timeout_p != 0);
  localparam logic [cnt_w-1:0] cnt_last =
    (timeout_p > 0) ? cnt_w'(timeout_p - 1) : {cnt_w{1'b0}};

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_req  = 2'd1,
    e_wait = 2'd2,
    e_resp = 2'd3
  } state_e;

  // Saturating increment for the timeout event counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  state_e           state, state_n;
  logic [cnt_w-1:0] cnt, cnt_n;
  logic             cmd_w, cmd_w_n;
  logic [22:0]      cmd_addr, cmd_addr_n;
  logic [7:0]       cmd_data, cmd_data_n;
  logic [31:0]      resp_data, resp_data_n;
  logic [7:0]       tcount, tcount_n;
  logic             timed_out;

  assign timed_out       = timeout_en && (cnt == cnt_last);
  assign ready_o         = reset_n_i && (state == e_idle);
  assign mem_v_o         = (state == e_req);
  assign v_o             = (state == e_resp);
  assign mem_w_o         = cmd_w;
  assign mem_addr_o      = cmd_addr;
  assign mem_data_o      = cmd_data;
  assign data_o          = resp_data;
  assign timeout_count_o = tcount;

  // Next-state and datapath update; handshakes take priority over timeout.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cmd_w_n     = cmd_w;
    cmd_addr_n  = cmd_addr;
    cmd_data_n  = cmd_data;
    resp_data_n = resp_data;
    tcount_n    = tcount;
    case (state)
      e_idle: begin
        if (v_i) begin
          cmd_w_n    = data_i[31];
          cmd_addr_n = data_i[30:8];
          cmd_data_n = data_i[7:0];
          cnt_n      = {cnt_w{1'b0}};
          state_n    = e_req;
        end else begin
          state_n = e_idle;
        end
      end
      e_req: begin
        if (mem_ready_i) begin
          cnt_n   = {cnt_w{1'b0}};
          state_n = cmd_w ? e_idle : e_wait;
        end else if (timed_out) begin
          tcount_n = sat_inc8(tcount);
          if (cmd_w) begin
            state_n = e_idle;
          end else begin
            resp_data_n = timeout_data_p;
            state_n     = e_resp;
          end
        end else if (timeout_en) begin
          cnt_n = cnt + cnt_w'(1);
        end else begin
          cnt_n = cnt;
        end
      end
      e_wait: begin
        if (mem_v_i) begin
          resp_data_n = {24'b0, mem_data_i};
          state_n     = e_resp;
        end else if (timed_out) begin
          tcount_n    = sat_inc8(tcount);
          resp_data_n = timeout_data_p;
          state_n     = e_resp;
        end else if (timeout_en) begin
          cnt_n = cnt + cnt_w'(1);
        end else begin
          cnt_n = cnt;
        end
      end
      e_resp: begin
        if (ready_i) begin
          state_n = e_idle;
        end else begin
          state_n = e_resp;
        end
      end
      default: begin
        state_n = e_idle;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state     <= e_idle;
      cnt       <= {cnt_w{1'b0}};
      cmd_w     <= 1'b0;
      cmd_addr  <= 23'd0;
      cmd_data  <= 8'd0;
      resp_data <= 32'd0;
      tcount    <= 8'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cmd_w     <= cmd_w_n;
      cmd_addr  <= cmd_addr_n;
      cmd_data  <= cmd_data_n;
      resp_data <= resp_data_n;
      tcount    <= tcount_n;
    end
  end

endmodule

// File: tb/tb_bsg_packed_cmd_executor.sv
// Directed self-checking bench for bsg_packed_cmd_executor (timeout_p=16).
module tb_bsg_packed_cmd_executor;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [31:0] data_i;
  logic        v_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        v_o;
  logic        ready_i;
  logic        mem_v_o;
  logic        mem_w_o;
  logic [22:0] mem_addr_o;
  logic [7:0]  mem_data_o;
  logic        mem_ready_i;
  logic [7:0]  mem_data_i;
  logic        mem_v_i;
  logic [7:0]  timeout_count_o;

  int errors = 0;
  int checks = 0;
  int n;
  logic [7:0] mem_model [0:255];

  bsg_packed_cmd_executor #(.timeout_p(16), .timeout_data_p(32'hDEAD_BEEF)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .data_i(data_i), .v_i(v_i),
    .ready_o(ready_o), .data_o(data_o), .v_o(v_o), .ready_i(ready_i),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i),
    .mem_v_i(mem_v_i), .timeout_count_o(timeout_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n_i = 1'b0; data_i = 32'd0; v_i = 1'b0; ready_i = 1'b0;
    mem_ready_i = 1'b0; mem_data_i = 8'd0; mem_v_i = 1'b0;
    step(); step();
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_vo", {31'd0, v_o}, 32'd0);
    chk("rst_memv", {31'd0, mem_v_o}, 32'd0);
    chk("rst_dataout", data_o, 32'd0);
    chk("rst_tcount", {24'd0, timeout_count_o}, 32'd0);
    reset_n_i = 1'b1;
    #1;
    chk("idle_ready", {31'd0, ready_o}, 32'd1);

    // Write 0xA5 to 0x12 with an immediately ready target
    data_i = 32'h8000_12A5; v_i = 1'b1; mem_ready_i = 1'b1;
    step();
    v_i = 1'b0;
    chk("wr_memv", {31'd0, mem_v_o}, 32'd1);
    chk("wr_memw", {31'd0, mem_w_o}, 32'd1);
    chk("wr_addr", {9'd0, mem_addr_o}, 32'h0000_0012);
    chk("wr_data", {24'd0, mem_data_o}, 32'h0000_00A5);
    chk("wr_busy", {31'd0, ready_o}, 32'd0);
    step();
    chk("wr_done_memv", {31'd0, mem_v_o}, 32'd0);
    chk("wr_done_ready", {31'd0, ready_o}, 32'd1);
    chk("wr_no_vo", {31'd0, v_o}, 32'd0);

    // Read of 0x34 with data arriving 5 cycles after the request
    data_i = 32'h0000_3400; v_i = 1'b1;
    step();
    v_i = 1'b0;
    chk("rd_memv", {31'd0, mem_v_o}, 32'd1);
    chk("rd_memw", {31'd0, mem_w_o}, 32'd0);
    chk("rd_addr", {9'd0, mem_addr_o}, 32'h0000_0034);
    step();
    mem_ready_i = 1'b0;
    chk("rd_wait_memv", {31'd0, mem_v_o}, 32'd0);
    step(); step(); step();
    chk("rd_wait_vo", {31'd0, v_o}, 32'd0);
    mem_v_i = 1'b1; mem_data_i = 8'h5C;
    step();
    mem_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rd_hold_vo", {31'd0, v_o}, 32'd1);
      chk("rd_hold_data", data_o, 32'h0000_005C);
      step();
    end
    chk("rd_hold_vo_last", {31'd0, v_o}, 32'd1);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("rd_release_vo", {31'd0, v_o}, 32'd0);
    chk("rd_release_ready", {31'd0, ready_o}, 32'd1);
    chk("rd_tcount", {24'd0, timeout_count_o}, 32'd0);

    // Read timeout: no data ever arrives
    data_i = 32'h0000_5600; v_i = 1'b1; mem_ready_i = 1'b1;
    step();
    v_i = 1'b0;
    step();
    mem_ready_i = 1'b0;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (v_o) break;
      n++;
    end
    chk("to_rd_wait_cycles", n, 32'd16);
    chk("to_rd_vo", {31'd0, v_o}, 32'd1);
    chk("to_rd_data", data_o, 32'hDEAD_BEEF);
    chk("to_rd_tcount", {24'd0, timeout_count_o}, 32'd1);
    mem_v_i = 1'b1; mem_data_i = 8'h77;
    step();
    mem_v_i = 1'b0;
    chk("stray_resp_data", data_o, 32'hDEAD_BEEF);
    chk("stray_resp_vo", {31'd0, v_o}, 32'd1);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    mem_v_i = 1'b1;
    step();
    mem_v_i = 1'b0;
    chk("stray_idle_ready", {31'd0, ready_o}, 32'd1);
    chk("stray_idle_vo", {31'd0, v_o}, 32'd0);
    chk("stray_idle_data", data_o, 32'hDEAD_BEEF);

    // Write timeout: target never ready
    data_i = 32'h8000_2011; v_i = 1'b1; mem_ready_i = 1'b0;
    step();
    v_i = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_v_o) break;
      n++;
      step();
    end
    chk("to_wr_memv_cycles", n, 32'd16);
    chk("to_wr_memv_low", {31'd0, mem_v_o}, 32'd0);
    chk("to_wr_no_vo", {31'd0, v_o}, 32'd0);
    chk("to_wr_tcount", {24'd0, timeout_count_o}, 32'd2);
    chk("to_wr_ready", {31'd0, ready_o}, 32'd1);

    // Write completing on the final allowed cycle is not a timeout
    data_i = 32'h8000_2122; v_i = 1'b1;
    step();
    v_i = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("last_wr_memv", {31'd0, mem_v_o}, 32'd1);
    mem_ready_i = 1'b1;
    step();
    chk("last_wr_memv_low", {31'd0, mem_v_o}, 32'd0);
    chk("last_wr_tcount", {24'd0, timeout_count_o}, 32'd2);
    chk("last_wr_ready", {31'd0, ready_o}, 32'd1);

    // Back-to-back write then read of the same address via a memory model
    data_i = 32'h8000_1042; v_i = 1'b1; mem_ready_i = 1'b1;
    step();
    data_i = 32'h0000_1000;
    chk("b2b_stall", {31'd0, ready_o}, 32'd0);
    if (mem_v_o && mem_w_o) mem_model[mem_addr_o[7:0]] = mem_data_o;
    step();
    chk("b2b_accept", {31'd0, ready_o}, 32'd1);
    step();
    v_i = 1'b0;
    chk("b2b_rd_memw", {31'd0, mem_w_o}, 32'd0);
    chk("b2b_rd_addr", {9'd0, mem_addr_o}, 32'h0000_0010);
    step();
    mem_v_i = 1'b1; mem_data_i = mem_model[8'h10];
    step();
    mem_v_i = 1'b0;
    chk("b2b_vo", {31'd0, v_o}, 32'd1);
    chk("b2b_data", data_o, 32'h0000_0042);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;

    // Reset during e_wait of a read
    data_i = 32'h0000_7700; v_i = 1'b1; mem_ready_i = 1'b1;
    step();
    v_i = 1'b0;
    step();
    mem_ready_i = 1'b0;
    reset_n_i = 1'b0;
    step();
    chk("mid_rst_ready", {31'd0, ready_o}, 32'd0);
    chk("mid_rst_vo", {31'd0, v_o}, 32'd0);
    chk("mid_rst_memv", {31'd0, mem_v_o}, 32'd0);
    chk("mid_rst_memw", {31'd0, mem_w_o}, 32'd0);
    chk("mid_rst_addr", {9'd0, mem_addr_o}, 32'd0);
    chk("mid_rst_mdata", {24'd0, mem_data_o}, 32'd0);
    chk("mid_rst_data", data_o, 32'd0);
    chk("mid_rst_tcount", {24'd0, timeout_count_o}, 32'd0);
    reset_n_i = 1'b1;
    mem_v_i = 1'b1; mem_data_i = 8'h99;
    step();
    mem_v_i = 1'b0;
    step(); step();
    chk("post_rst_vo", {31'd0, v_o}, 32'd0);
    chk("post_rst_data", data_o, 32'd0);
    chk("post_rst_ready", {31'd0, ready_o}, 32'd1);
    data_i = 32'h8000_0533; v_i = 1'b1; mem_ready_i = 1'b1;
    step();
    v_i = 1'b0;
    chk("post_rst_wr_addr", {9'd0, mem_addr_o}, 32'h0000_0005);
    chk("post_rst_wr_data", {24'd0, mem_data_o}, 32'h0000_0033);
    chk("post_rst_wr_memv", {31'd0, mem_v_o}, 32'd1);
    step();
    chk("post_rst_wr_done", {31'd0, ready_o}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
